// File: rtl/mat_mult_pkg.sv
// Shared types and helpers for the GF(2) matrix-vector multiplier sequencer.
// Holds the controller state encoding, default sizing and a reference multiply.
package mat_mult_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_FLUSH
    } state_t;

    localparam int DEF_A_ROWS    = 4;
    localparam int DEF_A_COLS    = 8;
    localparam int DEF_B_COLS    = 1;
    localparam int DEF_OUT_DEPTH = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_IDX_W = idx_width(DEF_A_ROWS);
    localparam int A_W       = DEF_A_ROWS * DEF_A_COLS;
    localparam int B_W       = DEF_A_COLS * DEF_B_COLS;
    localparam int C_W       = DEF_A_ROWS * DEF_B_COLS;

    // C[r][c] = XOR over k of A[r][k] AND B[k][c], using the default sizing
    function automatic logic [C_W-1:0] gf2_mat_vec(input logic [A_W-1:0] a,
                                                   input logic [B_W-1:0] b);
        logic [C_W-1:0] c;
        c = '0;
        for (int r = 0; r < DEF_A_ROWS; r++) begin
            for (int col = 0; col < DEF_B_COLS; col++) begin
                for (int k = 0; k < DEF_A_COLS; k++) begin
                    c[r*DEF_B_COLS+col] ^= a[r*DEF_A_COLS+k] & b[k*DEF_B_COLS+col];
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mat_mult_ofifo.sv
// Small synchronous result FIFO with occupancy count; simultaneous push and pop
// are allowed, including when full.
module mat_mult_ofifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mat_mult_ctrl.sv
// Sequencer for the GF(2) matrix-vector multiplier: loads and holds A, streams
// B vectors through the one-cycle multiplier and buffers results with credits.
module mat_mult_ctrl
    import mat_mult_pkg::*;
#(
    parameter int A_ROWS    = DEF_A_ROWS,
    parameter int A_COLS    = DEF_A_COLS,
    parameter int B_COLS    = DEF_B_COLS,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [idx_width(A_ROWS)-1:0]  cfg_row_idx,
    input  logic [A_COLS-1:0]             cfg_row_data,
    input  logic                          cfg_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [A_COLS*B_COLS-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [A_ROWS*B_COLS-1:0]      out_data,
    output logic [A_ROWS*A_COLS-1:0]      mm_a_data,
    output logic [A_COLS*B_COLS-1:0]      mm_b_data,
    input  logic [A_ROWS*B_COLS-1:0]      mm_c_data,
    output logic                          cfg_err
);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    state_t            state;
    state_t            state_next;
    logic [A_COLS-1:0] a_rows [A_ROWS];
    logic              v1;
    logic              v2;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W:0]    occupancy;
    logic              cfg_fire;
    logic              in_fire;
    logic              row_in_range;

    // Credits count everything already committed to the FIFO, ignoring a same-cycle pop
    assign occupancy    = {1'b0, fifo_count} + (CNT_W+1)'(v1) + (CNT_W+1)'(v2);
    assign cfg_fire     = cfg_valid & cfg_ready;
    assign in_fire      = in_valid & in_ready;
    assign row_in_range = (32'(cfg_row_idx) < A_ROWS);
    assign fifo_pop     = out_valid & out_ready;
    assign fifo_push    = v2 & (~fifo_full | fifo_pop);
    assign out_valid    = ~fifo_empty;

    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        in_ready   = 1'b0;
        case (state)
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && cfg_last) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = (occupancy < (CNT_W+1)'(OUT_DEPTH));
                if (cfg_valid) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!v1 && !v2 && fifo_empty) begin
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // A is only written while loading, so it is constant for every vector in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < A_ROWS; r++) begin
                a_rows[r] <= '0;
            end
            cfg_err <= 1'b0;
        end else if (cfg_fire) begin
            if (row_in_range) begin
                a_rows[cfg_row_idx] <= cfg_row_data;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    always_comb begin
        mm_a_data = '0;
        for (int r = 0; r < A_ROWS; r++) begin
            mm_a_data[r*A_COLS +: A_COLS] = a_rows[r];
        end
    end

    // v1: vector presented to the multiplier; v2: its result is on mm_c_data
    always_ff @(posedge clk) begin
        if (rst) begin
            mm_b_data <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
        end else begin
            v1 <= in_fire;
            v2 <= v1;
            if (in_fire) begin
                mm_b_data <= in_data;
            end
        end
    end

    mat_mult_ofifo #(
        .WIDTH (A_ROWS * B_COLS),
        .DEPTH (OUT_DEPTH)
    ) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mm_c_data),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// Directed bench for mat_mult_ctrl with an attached multiplier model and a
// result scoreboard; a second 3-row instance covers bad row indices and reset.
module tb_mat_mult_ctrl;
    import mat_mult_pkg::*;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_row_idx;
    logic [7:0]  cfg_row_data;
    logic        cfg_last;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [31:0] mm_a_data;
    logic [7:0]  mm_b_data;
    logic [3:0]  mm_c_data;
    logic        cfg_err;

    logic        rst3;
    logic        cfg_valid3;
    logic        cfg_ready3;
    logic [1:0]  cfg_row_idx3;
    logic [7:0]  cfg_row_data3;
    logic        cfg_last3;
    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  in_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [2:0]  out_data3;
    logic [23:0] mm_a_data3;
    logic [7:0]  mm_b_data3;
    logic [2:0]  mm_c_data3;
    logic        cfg_err3;

    int          n_checks;
    int          n_pass;
    int          pop_count;
    int          base;
    int          drops;
    int          accepted;
    int          n;
    logic [31:0] sh_a;
    logic [3:0]  exp_q [$];
    logic [3:0]  exp_v;
    logic        stall_prev;
    logic [3:0]  stall_data;
    logic [7:0]  data;
    logic        acc;
    logic [7:0]  rows [4] = '{8'hFF, 8'h0F, 8'hAA, 8'h01};
    logic [7:0]  rows3 [3] = '{8'h11, 8'h22, 8'h44};

    mat_mult_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_row_idx  (cfg_row_idx),
        .cfg_row_data (cfg_row_data),
        .cfg_last     (cfg_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .mm_a_data    (mm_a_data),
        .mm_b_data    (mm_b_data),
        .mm_c_data    (mm_c_data),
        .cfg_err      (cfg_err)
    );

    mat_mult_ctrl #(.A_ROWS(3)) dut3 (
        .clk          (clk),
        .rst          (rst3),
        .cfg_valid    (cfg_valid3),
        .cfg_ready    (cfg_ready3),
        .cfg_row_idx  (cfg_row_idx3),
        .cfg_row_data (cfg_row_data3),
        .cfg_last     (cfg_last3),
        .in_valid     (in_valid3),
        .in_ready     (in_ready3),
        .in_data      (in_data3),
        .out_valid    (out_valid3),
        .out_ready    (out_ready3),
        .out_data     (out_data3),
        .mm_a_data    (mm_a_data3),
        .mm_b_data    (mm_b_data3),
        .mm_c_data    (mm_c_data3),
        .cfg_err      (cfg_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered one-cycle multiplier models sharing each controller's reset
    always @(posedge clk) begin
        if (rst) mm_c_data <= '0;
        else     mm_c_data <= gf2_mat_vec(mm_a_data, mm_b_data);
    end

    always @(posedge clk) begin
        if (rst3) begin
            mm_c_data3 <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                mm_c_data3[r] <= ^(mm_a_data3[r*8 +: 8] & mm_b_data3);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic cv, input logic [1:0] idx, input logic [7:0] rd,
                                 input logic cl, input logic iv, input logic [7:0] id,
                                 input logic orr);
        cfg_valid    = cv;
        cfg_row_idx  = idx;
        cfg_row_data = rd;
        cfg_last     = cl;
        in_valid     = iv;
        in_data      = id;
        out_ready    = orr;
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on consumed output
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                checkOutput("stall_hold", {27'b0, out_valid, out_data}, {27'b0, 1'b1, stall_data});
            end
            if (out_valid && out_ready) begin
                checkOutput("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(exp_v));
                end
                pop_count++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(gf2_mat_vec(sh_a, in_data));
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        pop_count  = 0;
        sh_a       = '0;
        stall_prev = 1'b0;
        rst        = 1'b1;
        rst3       = 1'b1;
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 0);
        cfg_valid3 = 0; cfg_row_idx3 = 0; cfg_row_data3 = 0; cfg_last3 = 0;
        in_valid3 = 0; in_data3 = 0; out_ready3 = 0;
        tick(2);

        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mm_a", mm_a_data, 32'h0);
        checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2'(i), rows[i], (i == 3), 0, 8'h00, 0);
            checkOutput("load_cfg_ready", 32'(cfg_ready), 32'd1);
            sh_a[i*8 +: 8] = rows[i];
            tick(1);
        end
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 0);
        checkOutput("run_cfg_ready", 32'(cfg_ready), 32'd0);
        checkOutput("run_in_ready", 32'(in_ready), 32'd1);
        checkOutput("loaded_mm_a", mm_a_data, 32'h01AA0FFF);

        $display("[TB] two vectors, latency check");
        applyStimulus(0, 2'd0, 8'h00, 0, 1, 8'h0F, 0);
        tick(1);
        applyStimulus(0, 2'd0, 8'h00, 0, 1, 8'h01, 0);
        tick(1);
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 0);
        checkOutput("lat_not_early", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("lat_valid", 32'(out_valid), 32'd1);
        checkOutput("first_result", 32'(out_data), 32'h8);
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 1);
        tick(1);
        checkOutput("second_valid", 32'(out_valid), 32'd1);
        checkOutput("second_result", 32'(out_data), 32'hB);
        tick(1);
        checkOutput("drained_valid", 32'(out_valid), 32'd0);

        $display("[TB] back-to-back stream");
        drops = 0;
        base  = pop_count;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 2'd0, 8'h00, 0, 1, 8'($urandom_range(0, 255)), 1);
            if (!in_ready) drops++;
            tick(1);
        end
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 1);
        tick(3);
        checkOutput("b2b_ready_drops", 32'(drops), 32'd0);
        checkOutput("b2b_results", 32'(pop_count - base), 32'd16);
        checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] backpressure");
        accepted = 0;
        data     = 8'h3C;
        applyStimulus(0, 2'd0, 8'h00, 0, 1, data, 0);
        for (int i = 0; i < 8; i++) begin
            acc = in_ready;
            tick(1);
            if (acc) begin
                accepted++;
                data = data + 8'h11;
                applyStimulus(0, 2'd0, 8'h00, 0, 1, data, 0);
            end
        end
        checkOutput("bp_accepted", 32'(accepted), 32'd4);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        base = pop_count;
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 1);
        tick(5);
        checkOutput("bp_released", 32'(pop_count - base), 32'd4);
        checkOutput("bp_resume_ready", 32'(in_ready), 32'd1);
        drops = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 2'd0, 8'h00, 0, 1, 8'(8'hA5 ^ 8'(i)), 1);
            if (!in_ready) drops++;
            tick(1);
        end
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 1);
        tick(3);
        checkOutput("resume_drops", 32'(drops), 32'd0);
        checkOutput("resume_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] reload during run");
        base = pop_count;
        applyStimulus(0, 2'd0, 8'h00, 0, 1, 8'h5A, 1);
        tick(1);
        applyStimulus(1, 2'd2, 8'h00, 1, 1, 8'hC3, 1);
        checkOutput("flush_beat_ready", 32'(in_ready), 32'd1);
        tick(1);
        applyStimulus(1, 2'd2, 8'h00, 1, 0, 8'h00, 1);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        checkOutput("flush_cfg_ready", 32'(cfg_ready), 32'd0);
        n = 0;
        while (!cfg_ready && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput("flush_cycles", 32'(n), 32'd4);
        checkOutput("flush_popped", 32'(pop_count - base), 32'd2);
        sh_a[16 +: 8] = 8'h00;
        tick(1);
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("reload_cfg_ready", 32'(cfg_ready), 32'd0);
        checkOutput("reload_mm_a", mm_a_data, 32'h01000FFF);
        applyStimulus(0, 2'd0, 8'h00, 0, 1, 8'hFF, 1);
        tick(1);
        applyStimulus(0, 2'd0, 8'h00, 0, 0, 8'h00, 1);
        tick(2);
        checkOutput("reload_valid", 32'(out_valid), 32'd1);
        checkOutput("reload_result", 32'(out_data), 32'(gf2_mat_vec(sh_a, 8'hFF)));
        tick(2);
        checkOutput("reload_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] three-row instance");
        rst3 = 1'b0;
        tick(1);
        checkOutput("r3_cfg_err_init", 32'(cfg_err3), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cfg_valid3 = 1; cfg_row_idx3 = 2'(i); cfg_row_data3 = rows3[i]; cfg_last3 = 0;
            tick(1);
        end
        cfg_row_idx3 = 2'd3; cfg_row_data3 = 8'hFF; cfg_last3 = 1;
        tick(1);
        cfg_valid3 = 0; cfg_last3 = 0;
        checkOutput("r3_cfg_err", 32'(cfg_err3), 32'd1);
        checkOutput("r3_mm_a", 32'(mm_a_data3), 32'h442211);
        checkOutput("r3_in_run", 32'(cfg_ready3), 32'd0);
        in_valid3 = 1; in_data3 = 8'h0F; out_ready3 = 0;
        tick(8);
        checkOutput("r3_full_in_ready", 32'(in_ready3), 32'd0);
        checkOutput("r3_full_valid", 32'(out_valid3), 32'd1);
        checkOutput("r3_full_data", 32'(out_data3), 32'h7);
        rst3 = 1'b1;
        tick(1);
        checkOutput("r3_rst_valid", 32'(out_valid3), 32'd0);
        checkOutput("r3_rst_cfg_ready", 32'(cfg_ready3), 32'd1);
        checkOutput("r3_rst_in_ready", 32'(in_ready3), 32'd0);
        checkOutput("r3_rst_cfg_err", 32'(cfg_err3), 32'd0);
        checkOutput("r3_rst_mm_a", 32'(mm_a_data3), 32'h0);
        rst3 = 1'b0;
        in_valid3 = 0;
        tick(1);
        checkOutput("r3_post_valid", 32'(out_valid3), 32'd0);
        checkOutput("r3_post_load", 32'(cfg_ready3), 32'd1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
